// File: rtl/x25519_pkg.sv
// Shared constants and types for the X25519 field-arithmetic datapath.
// Elements are carried as 32 radix-2^8 limbs packed into 264 bits.
package x25519_pkg;

    localparam int X25519_NUM_LIMBS = 32;
    localparam int X25519_LIMB_BITS = 8;
    localparam int X25519_FOLD_MULT = 19;
    localparam int X25519_TOP_BITS  = 7;

    typedef logic [263:0] x25519_elem_t;

    typedef enum logic [1:0] {
        ACCUM,
        FOLD,
        DONE
    } squeeze_state_t;

endpackage

// File: rtl/x25519_mult_squeeze.sv
// Collects 32 unreduced column sums and squeezes them into 32 radix-2^8 limbs.
// Pass one carries through the columns; pass two folds 2^255 = 19 back into limb 0.
module x25519_mult_squeeze
    import x25519_pkg::*;
#(
    parameter int NUM_WORDS = 32,
    parameter int ACC_WIDTH = 34
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [31:0]  in_word,
    output logic         in_ready,
    output logic         out_valid,
    output logic [263:0] out,
    output logic         busy
);

    localparam logic [4:0] LAST_J    = 5'(NUM_WORDS - 1);
    localparam logic [4:0] LAST_FOLD = 5'(X25519_NUM_LIMBS - 2);
    localparam int         LB        = X25519_LIMB_BITS;

    squeeze_state_t         r_state;
    squeeze_state_t         w_state_next;
    logic [4:0]             r_j;
    logic [ACC_WIDTH-1:0]   r_u;
    logic [LB-1:0]          r_limb [0:X25519_NUM_LIMBS-2];
    logic [8:0]             r_limb31;
    x25519_elem_t           r_out;
    logic                   r_busy;

    logic                   w_accept;
    logic                   w_last_word;
    logic                   w_last_fold;
    logic [ACC_WIDTH-1:0]   w_acc_sum;
    logic [ACC_WIDTH-1:0]   w_fold_sum;
    logic [ACC_WIDTH-1:0]   w_top;
    logic [ACC_WIDTH-1:0]   w_fold_u;
    x25519_elem_t           w_pack;

    assign in_ready    = (r_state != FOLD);
    assign out_valid   = (r_state == DONE);
    assign out         = r_out;
    assign busy        = r_busy;

    assign w_accept    = in_valid && in_ready;
    assign w_last_word = (r_j == LAST_J);
    assign w_last_fold = (r_state == FOLD) && (r_j == LAST_FOLD);

    assign w_acc_sum  = r_u + {{(ACC_WIDTH-32){1'b0}}, in_word};
    assign w_fold_sum = r_u + {{(ACC_WIDTH-LB){1'b0}}, r_limb[r_j]};

    // Bits at and above 2^255 wrap around as 19x; written as shifts to stay adder-only.
    assign w_top    = w_acc_sum >> X25519_TOP_BITS;
    assign w_fold_u = (w_top << 4) + (w_top << 1) + w_top;

    // Final packed result as it will look after the last fold edge.
    generate
        for (genvar gi = 0; gi < X25519_NUM_LIMBS - 1; gi++) begin : g_pack
            if (gi == X25519_NUM_LIMBS - 2) begin : g_last
                assign w_pack[gi*LB +: LB] = w_fold_sum[LB-1:0];
            end else begin : g_mid
                assign w_pack[gi*LB +: LB] = r_limb[gi];
            end
        end
    endgenerate
    assign w_pack[263:248] = {7'b0, r_limb31 + w_fold_sum[16:8]};

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ACCUM: if (w_accept && w_last_word) w_state_next = FOLD;
            FOLD:  if (w_last_fold)             w_state_next = DONE;
            DONE:  w_state_next = (w_accept && w_last_word) ? FOLD : ACCUM;
            default: w_state_next = ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ACCUM;
            r_j      <= '0;
            r_u      <= '0;
            r_limb31 <= '0;
            r_out    <= '0;
            r_busy   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_busy <= 1'b1;
                if (w_last_word) begin
                    r_limb31 <= {2'b0, w_acc_sum[X25519_TOP_BITS-1:0]};
                    r_u      <= w_fold_u;
                    r_j      <= '0;
                end else begin
                    r_u <= w_acc_sum >> LB;
                    r_j <= r_j + 5'd1;
                end
            end else if (r_state == FOLD) begin
                if (w_last_fold) begin
                    // Residual carry is absorbed into limb31, so the next product starts from u=0.
                    r_limb31 <= w_pack[256:248];
                    r_out    <= w_pack;
                    r_u      <= '0;
                    r_j      <= '0;
                    r_busy   <= 1'b0;
                end else begin
                    r_u <= w_fold_sum >> LB;
                    r_j <= r_j + 5'd1;
                end
            end
        end
    end

    // Limb storage needs no reset: every product rewrites all limbs before they are read.
    always_ff @(posedge clk) begin
        if (w_accept && !w_last_word) begin
            r_limb[r_j] <= w_acc_sum[LB-1:0];
        end else if (r_state == FOLD) begin
            r_limb[r_j] <= w_fold_sum[LB-1:0];
        end
    end

endmodule

// File: tb/tb_x25519_mult_squeeze.sv
// Randomized and directed bench for x25519_mult_squeeze against an arithmetic squeeze model.
module tb_x25519_mult_squeeze;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic [31:0]  in_word;
    logic         in_ready;
    logic         out_valid;
    logic [263:0] out;
    logic         busy;

    int n_vec  = 0;
    int n_fail = 0;

    logic [31:0]  cur [32];
    logic [31:0]  nxt [32];
    logic [263:0] exp_q;

    x25519_mult_squeeze #(.NUM_WORDS(32), .ACC_WIDTH(34)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_word   (in_word),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out       (out),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [263:0] got, input logic [263:0] want);
        n_vec++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    // Software squeeze: carry pass, fold 2^255 -> 19, second carry pass.
    function automatic logic [263:0] ref_squeeze();
        longint unsigned u;
        longint unsigned limb [32];
        logic [263:0]    r;
        u = 0;
        for (int j = 0; j < 31; j++) begin
            u = u + longint'(cur[j]);
            limb[j] = u % 256;
            u = u / 256;
        end
        u = u + longint'(cur[31]);
        limb[31] = u % 128;
        u = (u / 128) * 19;
        for (int j = 0; j < 31; j++) begin
            u = u + limb[j];
            limb[j] = u % 256;
            u = u / 256;
        end
        limb[31] = limb[31] + u;
        r = '0;
        for (int j = 0; j < 31; j++) r[8*j +: 8] = limb[j][7:0];
        r[263:248] = limb[31][15:0];
        return r;
    endfunction

    task automatic feed(input int first);
        for (int k = first; k < 32; k++) begin
            @(negedge clk);
            chk("in_ready_accum", {263'b0, in_ready}, 264'd1);
            in_valid = 1'b1;
            in_word  = cur[k];
        end
    endtask

    // Waits for the result after word 31 has been driven; optionally jams in_valid during
    // the fold and optionally presents word 0 of nxt in the DONE cycle.
    task automatic wait_result(input string tag, input bit hold, input bit b2b);
        int cnt;
        exp_q = ref_squeeze();
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
            if (cnt == 1) begin
                chk({tag, "_busy_fold"}, {263'b0, busy}, 264'd1);
                chk({tag, "_ready_fold"}, {263'b0, in_ready}, 264'd0);
            end
            if (!out_valid) begin
                in_valid = hold;
                in_word  = $urandom;
            end
        end while (!out_valid && cnt < 60);
        chk({tag, "_latency"}, 264'(cnt), 264'd32);
        chk({tag, "_out"}, out, exp_q);
        chk({tag, "_busy_done"}, {263'b0, busy}, 264'd0);
        if (b2b) begin
            in_valid = 1'b1;
            in_word  = nxt[0];
        end else begin
            in_valid = 1'b0;
            @(negedge clk);
            chk({tag, "_valid_pulse"}, {263'b0, out_valid}, 264'd0);
            chk({tag, "_out_hold"}, out, exp_q);
            chk({tag, "_ready_idle"}, {263'b0, in_ready}, 264'd1);
        end
        $display("product %s: out=%0h", tag, out);
    endtask

    task automatic run(input string tag, input bit hold);
        feed(0);
        wait_result(tag, hold, 1'b0);
    endtask

    task automatic clear_words();
        for (int k = 0; k < 32; k++) cur[k] = '0;
    endtask

    task automatic rand_words();
        for (int k = 0; k < 32; k++) begin
            case ($urandom_range(0, 3))
                0:       cur[k] = 32'hFFFF_FFFF;
                1:       cur[k] = $urandom_range(0, 255);
                default: cur[k] = $urandom;
            endcase
        end
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_word  = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset_out", out, 264'd0);
        chk("reset_valid", {263'b0, out_valid}, 264'd0);
        chk("reset_ready", {263'b0, in_ready}, 264'd1);
        chk("reset_busy", {263'b0, busy}, 264'd0);

        clear_words();
        run("zeros", 1'b0);

        clear_words();
        cur[0] = 32'h0000_0100;
        run("word0_0x100", 1'b0);
        chk("word0_0x100_limb1", out, 264'h1 << 8);

        clear_words();
        cur[31] = 32'h0000_0080;
        run("word31_0x80", 1'b0);
        chk("word31_0x80_limb0", out, 264'h13);

        for (int k = 0; k < 31; k++) cur[k] = 32'h0000_00FF;
        cur[31] = 32'hFFFF_FFFF;
        run("overflow_fold", 1'b0);

        for (int k = 0; k < 32; k++) cur[k] = 32'h0100_0000 + 32'(k * 32'h0001_2345);
        cur[0]  = 32'h0112_30a2;
        cur[31] = 32'h0008_198f;
        run("ref_pair", 1'b0);

        rand_words();
        run("hold_in_fold", 1'b1);

        // Abort a product after word 17, then confirm a clean restart.
        rand_words();
        for (int k = 0; k < 18; k++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_word  = cur[k];
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_out", out, 264'd0);
        chk("midrst_busy", {263'b0, busy}, 264'd0);
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (out_valid) chk("midrst_no_valid", {263'b0, out_valid}, 264'd0);
        end
        chk("midrst_ready", {263'b0, in_ready}, 264'd1);
        rand_words();
        run("after_reset", 1'b0);

        // Back-to-back: word 0 of the second product lands in the DONE cycle.
        rand_words();
        for (int k = 0; k < 32; k++) nxt[k] = $urandom;
        feed(0);
        wait_result("b2b_first", 1'b0, 1'b1);
        for (int k = 0; k < 32; k++) cur[k] = nxt[k];
        feed(1);
        wait_result("b2b_second", 1'b0, 1'b0);

        for (int t = 0; t < 8; t++) begin
            rand_words();
            run($sformatf("random_%0d", t), t[0]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
